// File: rtl/stage_3_execute_pkg.sv
// stage_3_execute_pkg: opcode/function codes, mult/div FSM states and iteration count
// Rev 1.0
`default_nettype none

package stage_3_execute_pkg;

  localparam int MD_ITER = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/stage_3_muldiv.sv
// stage_3_muldiv: iterative shift-add multiplier / restoring divider owning HI/LO
// Rev 1.0
`default_nettype none

module stage_3_muldiv
  import stage_3_execute_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [5:0]       op_i,
  input  logic [5:0]       func_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(MD_ITER);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

  logic               rtype, md_req, signed_op, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, step, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Reset gates issue so stall is low for the whole time reset is held.
  assign rtype     = (op_i == OP_RTYPE);
  assign md_req    = rst_ni && rtype && (func_i == FN_MULT || func_i == FN_MULTU ||
                                         func_i == FN_DIV  || func_i == FN_DIVU);
  assign signed_op = (func_i == FN_MULT) || (func_i == FN_DIV);
  assign sa        = signed_op & a_i[WIDTH-1];
  assign sb        = signed_op & b_i[WIDTH-1];
  assign mag_a     = sa ? -a_i : a_i;
  assign mag_b     = sb ? -b_i : b_i;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign step     = is_div_q ? div_next : mul_next;
  assign prod_fix = neg_q ? -step : step;
  assign quot_fix = div0_q ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
  assign rem_fix  = neg_rem_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_o   = 1'b0;

    if (state_q != MD_BUSY && rtype) begin
      if (func_i == FN_MTHI) hi_d = a_i;
      if (func_i == FN_MTLO) lo_d = a_i;
    end

    case (state_q)
      MD_IDLE: begin
        if (md_req) begin
          stall_o   = 1'b1;
          acc_d     = {{WIDTH{1'b0}}, mag_a};
          opb_d     = mag_b;
          is_div_d  = func_i[1];
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          div0_d    = (b_i == '0);
          cnt_d     = '0;
          state_d   = MD_BUSY;
        end
      end
      MD_BUSY: begin
        stall_o = 1'b1;
        acc_d   = step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(MD_ITER - 1)) begin
          state_d = MD_DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/stage_3_execute.sv
// stage_3_execute: combinational ALU, branch compare and result mux around the mult/div unit
// Rev 1.0
`default_nettype none

module stage_3_execute
  import stage_3_execute_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [5:0]       op_i,
  input  logic [5:0]       func_i,
  input  logic [4:0]       shamt_i,
  input  logic [WIDTH-1:0] alu_data_1_i,
  input  logic [WIDTH-1:0] alu_data_2_i,
  input  logic [WIDTH-1:0] reg_data_2_i,
  input  logic [WIDTH-1:0] expand_imm_i,
  input  logic             branch_i,
  output logic [WIDTH-1:0] alu_result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             branch_taken_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] a, b, sum, diff, hi, lo;
  logic             add_ovf, sub_ovf, lt_s, lt_u;

  assign a       = alu_data_1_i;
  assign b       = alu_data_2_i;
  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;

  stage_3_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .op_i    (op_i),
    .func_i  (func_i),
    .a_i     (a),
    .b_i     (b),
    .stall_o (stall_o),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  assign hi_o           = hi;
  assign lo_o           = lo;
  assign zero_o         = (a == b);
  assign branch_taken_o = branch_i & ((op_i == OP_BEQ) ? zero_o : ~zero_o);

  always_comb begin
    alu_result_o = '0;
    overflow_o   = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (func_i)
          FN_ADD:  begin alu_result_o = sum;  overflow_o = add_ovf; end
          FN_ADDU: alu_result_o = sum;
          FN_SUB:  begin alu_result_o = diff; overflow_o = sub_ovf; end
          FN_SUBU: alu_result_o = diff;
          FN_AND:  alu_result_o = a & b;
          FN_OR:   alu_result_o = a | b;
          FN_XOR:  alu_result_o = a ^ b;
          FN_NOR:  alu_result_o = ~(a | b);
          FN_SLT:  alu_result_o = {{(WIDTH-1){1'b0}}, lt_s};
          FN_SLTU: alu_result_o = {{(WIDTH-1){1'b0}}, lt_u};
          FN_SLL:  alu_result_o = b << shamt_i;
          FN_SRL:  alu_result_o = b >> shamt_i;
          FN_SRA:  alu_result_o = $signed(b) >>> shamt_i;
          FN_SLLV: alu_result_o = b << a[4:0];
          FN_SRLV: alu_result_o = b >> a[4:0];
          FN_SRAV: alu_result_o = $signed(b) >>> a[4:0];
          FN_MFHI: alu_result_o = hi;
          FN_MFLO: alu_result_o = lo;
          default: alu_result_o = '0;
        endcase
      end
      OP_ADDI:  begin alu_result_o = sum; overflow_o = add_ovf; end
      OP_ADDIU: alu_result_o = sum;
      OP_SLTI:  alu_result_o = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTIU: alu_result_o = {{(WIDTH-1){1'b0}}, lt_u};
      OP_ANDI:  alu_result_o = a & b;
      OP_ORI:   alu_result_o = a | b;
      OP_XORI:  alu_result_o = a ^ b;
      OP_LUI:   alu_result_o = {expand_imm_i[15:0], {(WIDTH-16){1'b0}}};
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW:
                alu_result_o = sum;
      default:  alu_result_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_3_execute.sv
// tb_stage_3_execute: directed self-checking bench for the execute stage
// Rev 1.0
`default_nettype none

module tb_stage_3_execute;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [5:0]  op_i, func_i;
  logic [4:0]  shamt_i;
  logic [31:0] alu_data_1_i, alu_data_2_i, reg_data_2_i, expand_imm_i;
  logic        branch_i;
  logic [31:0] alu_result_o, hi_o, lo_o;
  logic        zero_o, overflow_o, branch_taken_o, stall_o;

  int n_pass  = 0;
  int n_total = 0;

  stage_3_execute dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .op_i           (op_i),
    .func_i         (func_i),
    .shamt_i        (shamt_i),
    .alu_data_1_i   (alu_data_1_i),
    .alu_data_2_i   (alu_data_2_i),
    .reg_data_2_i   (reg_data_2_i),
    .expand_imm_i   (expand_imm_i),
    .branch_i       (branch_i),
    .alu_result_o   (alu_result_o),
    .zero_o         (zero_o),
    .overflow_o     (overflow_o),
    .branch_taken_o (branch_taken_o),
    .stall_o        (stall_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive(input [5:0] op, input [5:0] fn, input [31:0] a, input [31:0] b,
                       input [4:0] sh);
    op_i = op; func_i = fn; alu_data_1_i = a; alu_data_2_i = b; shamt_i = sh;
    #1;
  endtask

  // Issues a mult/div from an aligned IDLE cycle and returns in its DONE cycle.
  task automatic issue_md(input [5:0] fn, input [31:0] a, input [31:0] b, output int cycles);
    @(posedge clk_i); #1;
    drive(6'h00, fn, a, b, 5'd0);
    cycles = stall_o ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (!stall_o) break;
      cycles++;
      alu_data_1_i = $urandom;
      alu_data_2_i = $urandom;
    end
  endtask

  task automatic leave_done();
    drive(6'h00, 6'h21, 32'd0, 32'd0, 5'd0);
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    n_total += 3;
    if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else n_pass++;
    if (hi_o !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", hi_o); else n_pass++;
    if (lo_o !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", lo_o); else n_pass++;
  endtask

  task automatic test_alu();
    drive(6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0);
    n_total += 2;
    if (alu_result_o !== 32'h8000_0000) $display("FAIL add_result: got %h expected 80000000", alu_result_o); else n_pass++;
    if (overflow_o !== 1'b1) $display("FAIL add_ovf: got %b expected 1", overflow_o); else n_pass++;
    drive(6'h00, 6'h21, 32'h7FFF_FFFF, 32'h1, 5'd0);
    n_total += 2;
    if (alu_result_o !== 32'h8000_0000) $display("FAIL addu_result: got %h expected 80000000", alu_result_o); else n_pass++;
    if (overflow_o !== 1'b0) $display("FAIL addu_ovf: got %b expected 0", overflow_o); else n_pass++;
    drive(6'h00, 6'h22, 32'h8000_0000, 32'h1, 5'd0);
    n_total += 2;
    if (alu_result_o !== 32'h7FFF_FFFF) $display("FAIL sub_result: got %h expected 7fffffff", alu_result_o); else n_pass++;
    if (overflow_o !== 1'b1) $display("FAIL sub_ovf: got %b expected 1", overflow_o); else n_pass++;
    drive(6'h00, 6'h27, 32'h0F0F_0000, 32'h0000_00F0, 5'd0);
    n_total++;
    if (alu_result_o !== 32'hF0F0_FF0F) $display("FAIL nor: got %h expected f0f0ff0f", alu_result_o); else n_pass++;
    expand_imm_i = 32'h0000_1234;
    drive(6'h0F, 6'h00, 32'h0, 32'h0, 5'd0);
    n_total++;
    if (alu_result_o !== 32'h1234_0000) $display("FAIL lui: got %h expected 12340000", alu_result_o); else n_pass++;
    drive(6'h23, 6'h3F, 32'h0000_1000, 32'hFFFF_FFFC, 5'd0);
    n_total++;
    if (alu_result_o !== 32'h0000_0FFC) $display("FAIL lw_addr: got %h expected 00000ffc", alu_result_o); else n_pass++;
  endtask

  task automatic test_shift_compare();
    drive(6'h00, 6'h03, 32'h0, 32'hF000_0000, 5'd4);
    n_total++;
    if (alu_result_o !== 32'hFF00_0000) $display("FAIL sra: got %h expected ff000000", alu_result_o); else n_pass++;
    drive(6'h00, 6'h06, 32'h0000_0024, 32'h0000_0080, 5'd0);
    n_total++;
    if (alu_result_o !== 32'h0000_0008) $display("FAIL srlv: got %h expected 00000008", alu_result_o); else n_pass++;
    drive(6'h00, 6'h2B, 32'h1, 32'hFFFF_FFFF, 5'd0);
    n_total++;
    if (alu_result_o !== 32'h1) $display("FAIL sltu: got %h expected 00000001", alu_result_o); else n_pass++;
    drive(6'h00, 6'h2A, 32'h1, 32'hFFFF_FFFF, 5'd0);
    n_total++;
    if (alu_result_o !== 32'h0) $display("FAIL slt: got %h expected 00000000", alu_result_o); else n_pass++;
  endtask

  task automatic test_branch();
    branch_i = 1'b1;
    drive(6'h04, 6'h00, 32'd5, 32'd5, 5'd0);
    n_total += 2;
    if (zero_o !== 1'b1) $display("FAIL beq_zero: got %b expected 1", zero_o); else n_pass++;
    if (branch_taken_o !== 1'b1) $display("FAIL beq_taken: got %b expected 1", branch_taken_o); else n_pass++;
    drive(6'h05, 6'h00, 32'd5, 32'd5, 5'd0);
    n_total++;
    if (branch_taken_o !== 1'b0) $display("FAIL bne_taken: got %b expected 0", branch_taken_o); else n_pass++;
    drive(6'h05, 6'h00, 32'd5, 32'd6, 5'd0);
    n_total++;
    if (branch_taken_o !== 1'b1) $display("FAIL bne_diff: got %b expected 1", branch_taken_o); else n_pass++;
    branch_i = 1'b0;
  endtask

  task automatic test_mthi_mtlo();
    @(posedge clk_i); #1;
    drive(6'h00, 6'h11, 32'hCAFE_BABE, 32'h0, 5'd0);
    @(posedge clk_i); #1;
    drive(6'h00, 6'h13, 32'h1234_5678, 32'h0, 5'd0);
    @(posedge clk_i); #1;
    drive(6'h00, 6'h10, 32'h0, 32'h0, 5'd0);
    n_total++;
    if (alu_result_o !== 32'hCAFE_BABE) $display("FAIL mfhi: got %h expected cafebabe", alu_result_o); else n_pass++;
    drive(6'h00, 6'h12, 32'h0, 32'h0, 5'd0);
    n_total++;
    if (alu_result_o !== 32'h1234_5678) $display("FAIL mflo: got %h expected 12345678", alu_result_o); else n_pass++;
  endtask

  task automatic test_mult();
    int cyc;
    issue_md(6'h18, 32'hFFFF_FFFD, 32'd7, cyc);
    n_total += 3;
    if (cyc !== 33) $display("FAIL mult_stall: got %0d cycles expected 33", cyc); else n_pass++;
    if (hi_o !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi_o); else n_pass++;
    if (lo_o !== 32'hFFFF_FFEB) $display("FAIL mult_lo: got %h expected ffffffeb", lo_o); else n_pass++;
    @(posedge clk_i); #1;
    drive(6'h00, 6'h12, 32'h0, 32'h0, 5'd0);
    n_total += 2;
    if (alu_result_o !== 32'hFFFF_FFEB) $display("FAIL mult_mflo: got %h expected ffffffeb", alu_result_o); else n_pass++;
    if (stall_o !== 1'b0) $display("FAIL mult_idle: got %b expected 0", stall_o); else n_pass++;
  endtask

  task automatic test_divide();
    int cyc;
    issue_md(6'h1A, 32'hFFFF_FFF9, 32'd2, cyc);
    n_total += 3;
    if (cyc !== 33) $display("FAIL div_stall: got %0d cycles expected 33", cyc); else n_pass++;
    if (lo_o !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", lo_o); else n_pass++;
    if (hi_o !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", hi_o); else n_pass++;
    leave_done();
    issue_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_total += 2;
    if (lo_o !== 32'h8000_0000) $display("FAIL divmin_lo: got %h expected 80000000", lo_o); else n_pass++;
    if (hi_o !== 32'h0) $display("FAIL divmin_hi: got %h expected 00000000", hi_o); else n_pass++;
    leave_done();
    issue_md(6'h1B, 32'd100, 32'd7, cyc);
    n_total += 2;
    if (lo_o !== 32'd14) $display("FAIL divu_lo: got %h expected 0000000e", lo_o); else n_pass++;
    if (hi_o !== 32'd2) $display("FAIL divu_hi: got %h expected 00000002", hi_o); else n_pass++;
    leave_done();
    issue_md(6'h1B, 32'd9, 32'd0, cyc);
    n_total += 3;
    if (cyc !== 33) $display("FAIL div0_stall: got %0d cycles expected 33", cyc); else n_pass++;
    if (lo_o !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h expected ffffffff", lo_o); else n_pass++;
    if (hi_o !== 32'd9) $display("FAIL div0_hi: got %h expected 00000009", hi_o); else n_pass++;
    leave_done();
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    @(posedge clk_i); #1;
    drive(6'h00, 6'h19, 32'h0000_1234, 32'h0000_5678, 5'd0);
    repeat (11) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    n_total += 3;
    if (stall_o !== 1'b0) $display("FAIL rst_mid_stall: got %b expected 0", stall_o); else n_pass++;
    if (hi_o !== 32'h0) $display("FAIL rst_mid_hi: got %h expected 00000000", hi_o); else n_pass++;
    if (lo_o !== 32'h0) $display("FAIL rst_mid_lo: got %h expected 00000000", lo_o); else n_pass++;
    drive(6'h00, 6'h21, 32'h0, 32'h0, 5'd0);
    rst_ni = 1'b1;
    issue_md(6'h19, 32'hFFFF_FFFF, 32'd2, cyc);
    n_total += 3;
    if (cyc !== 33) $display("FAIL multu_stall: got %0d cycles expected 33", cyc); else n_pass++;
    if (hi_o !== 32'h1) $display("FAIL multu_hi: got %h expected 00000001", hi_o); else n_pass++;
    if (lo_o !== 32'hFFFF_FFFE) $display("FAIL multu_lo: got %h expected fffffffe", lo_o); else n_pass++;
    leave_done();
  endtask

  initial begin
    rst_ni = 1'b0;
    op_i = 6'h00; func_i = 6'h00; shamt_i = 5'd0;
    alu_data_1_i = 32'h0; alu_data_2_i = 32'h0;
    reg_data_2_i = 32'h0; expand_imm_i = 32'h0; branch_i = 1'b0;
    #12;
    test_reset();
    rst_ni = 1'b1;
    test_alu();
    test_shift_compare();
    test_branch();
    test_mthi_mtlo();
    test_mult();
    leave_done();
    test_divide();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
